// File: rtl/axis_switch_router_pkg.sv
// axis_switch_pkg: shared definitions for the 1-to-NUM_M AXI4-Stream router.
//   - state_e   : FSM state encoding (IDLE/ROUTE/DROP/BCAST)
//   - clog2     : ceiling log2 for elaboration-time sizing
//   - bcast_dest: all-ones TDEST value for a given TDEST width
package axis_switch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2,
    BCAST = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // All-ones TDEST of the given width (widths up to 16 bits).
  function automatic logic [15:0] bcast_dest(input int width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/axis_switch_router_if.sv
// axis_switch_router_if: stream bus between one source, the router and NUM_M sinks.
//   Slave side : i_s_tvalid/i_s_tlast/i_s_tdest/i_s_tdata in, o_s_tready out
//   Master side: i_m_tready in, o_m_tvalid/o_m_tdest/o_m_tdata/o_m_tlast out
//                (port i at [i*W +: W] in the packed vectors)
// Modports:
//   slave  - the router's view (consumes the source stream, drives the sinks)
//   master - the environment's view (drives the source stream and sink readies)
interface axis_switch_router_if #(
  parameter int NUM_M  = 2,
  parameter int DATA_W = 8,
  parameter int DEST_W = 5
);

  logic                     i_s_tvalid;
  logic                     i_s_tlast;
  logic [DEST_W-1:0]        i_s_tdest;
  logic [DATA_W-1:0]        i_s_tdata;
  logic                     o_s_tready;
  logic [NUM_M-1:0]         i_m_tready;
  logic [NUM_M-1:0]         o_m_tvalid;
  logic [NUM_M*DEST_W-1:0]  o_m_tdest;
  logic [NUM_M*DATA_W-1:0]  o_m_tdata;
  logic [NUM_M-1:0]         o_m_tlast;

  modport slave (
    input  i_s_tvalid, i_s_tlast, i_s_tdest, i_s_tdata, i_m_tready,
    output o_s_tready, o_m_tvalid, o_m_tdest, o_m_tdata, o_m_tlast
  );

  modport master (
    output i_s_tvalid, i_s_tlast, i_s_tdest, i_s_tdata, i_m_tready,
    input  o_s_tready, o_m_tvalid, o_m_tdest, o_m_tdata, o_m_tlast
  );

endinterface

// File: rtl/axis_switch_router_out_slice.sv
// axis_out_slice: one registered output slot of the router.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_load                : capture i_tdata/i_tdest/i_tlast and raise o_tvalid
//   i_tready              : downstream ready
//   o_tvalid/o_tdata/...  : registered master-side beat
//   o_free                : slot can take a new beat this cycle
module axis_out_slice #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic [DEST_W-1:0] i_tdest,
  input  logic              i_tlast,
  input  logic              i_tready,
  output logic              o_tvalid,
  output logic [DATA_W-1:0] o_tdata,
  output logic [DEST_W-1:0] o_tdest,
  output logic              o_tlast,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [DEST_W-1:0] r_dest;
  logic              r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_dest  <= '0;
      r_last  <= 1'b0;
    end else begin
      // A load wins over completion: the slot is refilled in the same cycle
      // the held beat leaves, which keeps the path at full throughput.
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_tdata;
        r_dest  <= i_tdest;
        r_last  <= i_tlast;
      end else if (r_valid && i_tready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_tvalid = r_valid;
  assign o_tdata  = r_data;
  assign o_tdest  = r_dest;
  assign o_tlast  = r_last;
  assign o_free   = !r_valid || i_tready;

endmodule

// File: rtl/axis_switch_router.sv
// axis_switch_router: 1-to-NUM_M AXI4-Stream packet router.
// The first-beat TDEST selects the output port; the route is held until TLAST.
// Undecodable TDEST values are consumed and dropped with a one-cycle o_decerr.
// Ports:
//   i_switch_clk, i_switch_rst : clock, asynchronous active-high reset
//   sw (slave modport)         : source stream in, NUM_M registered streams out
//   o_decerr                   : one-cycle pulse when a packet enters DROP
//   o_busy                     : high while a packet is being handled
// Optional build macro AXIS_SWITCH_BCAST_EN: all-ones TDEST copies the packet
// to every output port.
module axis_switch_router
  import axis_switch_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int DATA_W = 8,
  parameter int DEST_W = 5
) (
  input  logic               i_switch_clk,
  input  logic               i_switch_rst,
  axis_switch_router_if.slave sw,
  output logic               o_decerr,
  output logic               o_busy
);

  localparam int SEL_W = clog2(NUM_M);
  localparam logic [DEST_W:0] NUM_M_D = (DEST_W+1)'(NUM_M);
`ifdef AXIS_SWITCH_BCAST_EN
  localparam logic [DEST_W-1:0] BCAST_DEST = DEST_W'(bcast_dest(DEST_W));
`endif

  state_e            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic              r_decerr;
  logic              w_s_tready;
  logic              w_accept;
  logic              w_dest_ok;
  logic [NUM_M-1:0]  w_free;
  logic [NUM_M-1:0]  w_load;

  assign w_accept  = sw.i_s_tvalid && w_s_tready;
  assign w_dest_ok = {1'b0, sw.i_s_tdest} < NUM_M_D;

  // Source ready depends on which output slot(s) the locked route targets.
  always_comb begin
    w_s_tready = 1'b0;
    case (r_state)
      ROUTE:   w_s_tready = w_free[r_sel];
      DROP:    w_s_tready = 1'b1;
`ifdef AXIS_SWITCH_BCAST_EN
      BCAST:   w_s_tready = &w_free;
`endif
      default: w_s_tready = 1'b0;
    endcase
  end

  // The header beat is only inspected in IDLE, not consumed; it is accepted
  // again once the route state is set up.
  always_ff @(posedge i_switch_clk or posedge i_switch_rst) begin
    if (i_switch_rst) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_decerr <= 1'b0;
    end else begin
      r_decerr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sw.i_s_tvalid) begin
            r_sel <= sw.i_s_tdest[SEL_W-1:0];
`ifdef AXIS_SWITCH_BCAST_EN
            if (sw.i_s_tdest == BCAST_DEST) begin
              r_state <= BCAST;
            end else
`endif
            if (w_dest_ok) begin
              r_state <= ROUTE;
            end else begin
              r_state  <= DROP;
              r_decerr <= 1'b1;
            end
          end
        end
        default: begin
          if (w_accept && sw.i_s_tlast) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_decerr      = r_decerr;
  assign o_busy        = (r_state != IDLE);
  assign sw.o_s_tready = w_s_tready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_slot
      logic w_hit;
`ifdef AXIS_SWITCH_BCAST_EN
      assign w_hit = ((r_state == ROUTE) && (r_sel == SEL_W'(gi))) ||
                     (r_state == BCAST);
`else
      assign w_hit = (r_state == ROUTE) && (r_sel == SEL_W'(gi));
`endif
      assign w_load[gi] = w_accept && w_hit;

      axis_out_slice #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W)
      ) u_slice (
        .i_clk    (i_switch_clk),
        .i_rst    (i_switch_rst),
        .i_load   (w_load[gi]),
        .i_tdata  (sw.i_s_tdata),
        .i_tdest  (sw.i_s_tdest),
        .i_tlast  (sw.i_s_tlast),
        .i_tready (sw.i_m_tready[gi]),
        .o_tvalid (sw.o_m_tvalid[gi]),
        .o_tdata  (sw.o_m_tdata[gi*DATA_W +: DATA_W]),
        .o_tdest  (sw.o_m_tdest[gi*DEST_W +: DEST_W]),
        .o_tlast  (sw.o_m_tlast[gi]),
        .o_free   (w_free[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_axis_switch_router.sv
// Bench for axis_switch_router with NUM_M=4, DATA_W=8, DEST_W=5.
// Expected beats are queued per output port as the source handshake happens
// and are checked when the corresponding master handshake happens.
module tb_axis_switch_router;

  localparam int NUM_M  = 4;
  localparam int DATA_W = 8;
  localparam int DEST_W = 5;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic decerr;
  logic busy;

  always #5 clk = ~clk;

  axis_switch_router_if #(.NUM_M(NUM_M), .DATA_W(DATA_W), .DEST_W(DEST_W)) sw_if ();

  axis_switch_router #(.NUM_M(NUM_M), .DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .i_switch_clk (clk),
    .i_switch_rst (rst),
    .sw           (sw_if),
    .o_decerr     (decerr),
    .o_busy       (busy)
  );

  beat_t exp_q [NUM_M][$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    decerr_cnt  = 0;
  int    cyc         = 0;
  bit    rand_en     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_M; i++) n += exp_q[i].size();
    return n;
  endfunction

  // -1 = dropped, -2 = every port, otherwise the port number.
  function automatic int route_of(input logic [DEST_W-1:0] d);
`ifdef AXIS_SWITCH_BCAST_EN
    if (d == {DEST_W{1'b1}}) return -2;
`endif
    if (int'(d) < NUM_M) return int'(d);
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Sink-side monitor: a beat completes at the next rising edge when
  // valid and ready are both high here.
  always @(negedge clk) begin
    if (!rst) begin
      if (decerr) decerr_cnt++;
      for (int i = 0; i < NUM_M; i++) begin
        if (sw_if.o_m_tvalid[i] && sw_if.i_m_tready[i]) begin
          beat_t got;
          beat_t e;
          got.dest = sw_if.o_m_tdest[i*DEST_W +: DEST_W];
          got.data = sw_if.o_m_tdata[i*DATA_W +: DATA_W];
          got.last = sw_if.o_m_tlast[i];
          $display("port %0d beat: data=%02h dest=%0d last=%0b", i, got.data, got.dest, got.last);
          if (exp_q[i].size() == 0) begin
            check($sformatf("port%0d_beat_expected", i), 32'(exp_q[i].size() > 0), 32'd1);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("port%0d_beat", i), 32'(got), 32'(e));
          end
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_en) sw_if.i_m_tready = 4'($urandom);
  end

  // Sends n_send beats of a len-beat packet; beat k carries base + k*step.
  task automatic send_pkt(input logic [DEST_W-1:0] d0, input logic [DEST_W-1:0] drest,
                          input int len, input int n_send,
                          input logic [7:0] base, input logic [7:0] step);
    int    route;
    beat_t b;
    route = route_of(d0);
    for (int k = 0; k < n_send; k++) begin
      int waitc = 0;
      bit done  = 1'b0;
      b.dest = (k == 0) ? d0 : drest;
      b.data = base + 8'(k) * step;
      b.last = (k == len - 1);
      sw_if.i_s_tvalid = 1'b1;
      sw_if.i_s_tdest  = b.dest;
      sw_if.i_s_tdata  = b.data;
      sw_if.i_s_tlast  = b.last;
      while (!done) begin
        @(negedge clk);
        if (sw_if.o_s_tready) begin
          done = 1'b1;
          check("busy_in_pkt", 32'(busy), 32'd1);
          if (route >= 0) exp_q[route].push_back(b);
          else if (route == -2) for (int i = 0; i < NUM_M; i++) exp_q[i].push_back(b);
        end else if (++waitc > 200) begin
          check("accept_timeout", 32'(waitc), 32'd0);
          done = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    end
    sw_if.i_s_tvalid = 1'b0;
    sw_if.i_s_tlast  = 1'b0;
    if (n_send == len) check("idle_after_pkt", 32'(busy), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (pending() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check({tag, "_left"}, 32'(pending()), 32'd0);
    check({tag, "_mvalid"}, 32'(sw_if.o_m_tvalid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d0;
    rst = 1'b1;
    sw_if.i_s_tvalid = 1'b0;
    sw_if.i_s_tlast  = 1'b0;
    sw_if.i_s_tdest  = '0;
    sw_if.i_s_tdata  = '0;
    sw_if.i_m_tready = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(sw_if.o_m_tvalid), 32'd0);
    check("rst_m_tdata",  32'(sw_if.o_m_tdata), 32'd0);
    check("rst_m_tdest",  32'(sw_if.o_m_tdest), 32'd0);
    check("rst_m_tlast",  32'(sw_if.o_m_tlast), 32'd0);
    check("rst_s_tready", 32'(sw_if.o_s_tready), 32'd0);
    check("rst_decerr",   32'(decerr), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic route: one IDLE bubble then one beat per cycle.
    c0 = cyc;
    send_pkt(5'd2, 5'd2, 3, 3, 8'h11, 8'h11);
    check("route_cycles", 32'(cyc - c0), 32'd4);
    drain("basic");

    // Backpressure on port 2 for 5 cycles.
    fork
      send_pkt(5'd2, 5'd2, 3, 3, 8'h11, 8'h11);
      begin
        sw_if.i_m_tready = 4'b1011;
        repeat (3) @(posedge clk);
        #1;
        check("bp_s_tready",   32'(sw_if.o_s_tready), 32'd0);
        check("bp_hold_valid", 32'(sw_if.o_m_tvalid), 32'b0100);
        check("bp_hold_data",  32'(sw_if.o_m_tdata[2*DATA_W +: DATA_W]), 32'h11);
        repeat (2) @(posedge clk);
        #1;
        check("bp_still_data", 32'(sw_if.o_m_tdata[2*DATA_W +: DATA_W]), 32'h11);
        sw_if.i_m_tready = '1;
      end
    join
    drain("backpressure");

    // Decode error: dropped at one beat per cycle with a single o_decerr.
    d0 = decerr_cnt;
    c0 = cyc;
    send_pkt(5'd7, 5'd7, 2, 2, 8'h40, 8'h01);
    check("drop_cycles", 32'(cyc - c0), 32'd3);
    drain("decerr");
    check("decerr_pulses", 32'(decerr_cnt - d0), 32'd1);

    // Route lock: later beats carry tdest=3 but stay on port 0.
    send_pkt(5'd0, 5'd3, 3, 3, 8'hA0, 8'h01);
    drain("lock");

    // Single-beat packet.
    c0 = cyc;
    send_pkt(5'd1, 5'd1, 1, 1, 8'h5A, 8'h00);
    check("single_cycles", 32'(cyc - c0), 32'd2);
    drain("single");

    // Reset mid-packet with a beat held in slot 1.
    send_pkt(5'd1, 5'd1, 4, 2, 8'hC0, 8'h01);
    sw_if.i_m_tready = 4'b1101;
    #2;
    check("pre_rst_valid", 32'(sw_if.o_m_tvalid), 32'b0010);
    rst = 1'b1;
    #1;
    check("async_rst_valid",  32'(sw_if.o_m_tvalid), 32'd0);
    check("async_rst_data",   32'(sw_if.o_m_tdata), 32'd0);
    check("async_rst_last",   32'(sw_if.o_m_tlast), 32'd0);
    check("async_rst_busy",   32'(busy), 32'd0);
    check("async_rst_tready", 32'(sw_if.o_s_tready), 32'd0);
    for (int i = 0; i < NUM_M; i++) exp_q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sw_if.i_m_tready = '1;
    @(posedge clk);
    #1;
    send_pkt(5'd0, 5'd0, 2, 2, 8'h77, 8'h01);
    drain("post_rst");

`ifdef AXIS_SWITCH_BCAST_EN
    // Broadcast with port 1 stalled for 3 cycles.
    fork
      send_pkt(5'h1F, 5'h1F, 2, 2, 8'hB0, 8'h01);
      begin
        sw_if.i_m_tready = 4'b1101;
        repeat (3) @(posedge clk);
        #1;
        check("bc_stall",  32'(sw_if.o_s_tready), 32'd0);
        check("bc_held",   32'(sw_if.o_m_tvalid), 32'b0010);
        sw_if.i_m_tready = '1;
      end
    join
    drain("bcast");
`endif

    // Random packets under random sink backpressure.
    rand_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      logic [DEST_W-1:0] d;
      int len;
      d   = DEST_W'($urandom_range(0, 6));
      len = $urandom_range(1, 4);
      send_pkt(d, DEST_W'($urandom_range(0, 6)), len, len, 8'($urandom), 8'h03);
    end
    rand_en = 1'b0;
    sw_if.i_m_tready = '1;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
